intersection_controller: RTL and testbench

Phase sequencer for a two-road intersection (main road NS, side road EW). It enables the free-running master timer, converts the timer's 1 Hz square wave into one-cycle second ticks, and drives both signal heads and the pedestrian WALK lamp through a timed, request-driven state machine. It sits between the master timer and the lamp drivers and is the only block that sequences lights.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/phase_timer.sv | 29 ++
 rtl/intersection_controller.sv | 116 +++++++++++
 tb/tb_intersection_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp codes for the intersection phase sequencer.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_NS_GREEN,
    ST_NS_YELLOW,
    ST_RED_A,
    ST_EW_GREEN,
    ST_EW_YELLOW,
    ST_RED_B,
    ST_FLASH
  } state_t;

  // Lamp heads are {red, yellow, green}
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Second-tick edge detector on the master timer square wave plus a
// clearable, saturating seconds counter.
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_50_mhz,
  input  logic             rst,
  input  logic             clk_mstr,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  logic clk_mstr_d;

  always_ff @(posedge clk_50_mhz) begin
    if (rst) clk_mstr_d <= 1'b0;
    else     clk_mstr_d <= clk_mstr;
  end

  assign tick = clk_mstr & ~clk_mstr_d;

  // Clear (state entry) takes priority over a coincident tick
  always_ff @(posedge clk_50_mhz) begin
    if (rst || clear)              count <= '0;
    else if (tick && (count != '1)) count <= count + 1'b1;
  end

endmodule

// File: rtl/intersection_controller.sv
// Two-road intersection phase sequencer: timed, request-driven signal heads,
// pedestrian WALK lamp and night/fault flash mode.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int unsigned NS_MIN_T = 8,
  parameter int unsigned EW_T     = 6,
  parameter int unsigned YEL_T    = 3,
  parameter int unsigned ALLRED_T = 1,
  parameter int unsigned WALK_T   = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk_50_mhz,
  input  logic       rst,
  input  logic       clk_mstr,
  output logic       timer_enable_n,
  input  logic       ew_sensor,
  input  logic       ped_btn,
  input  logic       flash,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic       walk
);

  localparam logic [CNT_W-1:0] NS_LAST     = CNT_W'(NS_MIN_T - 1);
  localparam logic [CNT_W-1:0] EW_LAST     = CNT_W'(EW_T - 1);
  localparam logic [CNT_W-1:0] YEL_LAST    = CNT_W'(YEL_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LIM    = CNT_W'(WALK_T);

  state_t           state, state_nxt;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             enter, enter_ew;
  logic             ew_req, ped_req, walk_en, flash_on;

  phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk_50_mhz (clk_50_mhz),
    .rst        (rst),
    .clk_mstr   (clk_mstr),
    .clear      (enter),
    .tick       (tick),
    .count      (count)
  );

  always_ff @(posedge clk_50_mhz) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flash) begin
      state_nxt = ST_FLASH;
    end else begin
      case (state)
        ST_INIT:      if (tick && count == ALLRED_LAST) state_nxt = ST_NS_GREEN;
        ST_NS_GREEN:  if (tick && count >= NS_LAST && ew_req) state_nxt = ST_NS_YELLOW;
        ST_NS_YELLOW: if (tick && count == YEL_LAST) state_nxt = ST_RED_A;
        ST_RED_A:     if (tick && count == ALLRED_LAST) state_nxt = ST_EW_GREEN;
        ST_EW_GREEN:  if (tick && count == EW_LAST) state_nxt = ST_EW_YELLOW;
        ST_EW_YELLOW: if (tick && count == YEL_LAST) state_nxt = ST_RED_B;
        ST_RED_B:     if (tick && count == ALLRED_LAST) state_nxt = ST_NS_GREEN;
        ST_FLASH:     state_nxt = ST_INIT;
        default:      state_nxt = ST_INIT;
      endcase
    end
    enter    = (state_nxt != state);
    enter_ew = enter && (state_nxt == ST_EW_GREEN);
  end

  // Requests clear on EW green entry, but a same-cycle set is kept
  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      ew_req  <= 1'b0;
      ped_req <= 1'b0;
      walk_en <= 1'b0;
    end else begin
      ew_req  <= (ew_req  & ~enter_ew) | ew_sensor | ped_btn;
      ped_req <= (ped_req & ~enter_ew) | ped_btn;
      if (enter_ew) walk_en <= ped_req;
    end
  end

  always_ff @(posedge clk_50_mhz) begin
    if (rst)                                  flash_on <= 1'b0;
    else if (enter && state_nxt == ST_FLASH)  flash_on <= 1'b1;
    else if (state == ST_FLASH && tick)       flash_on <= ~flash_on;
  end

  always_ff @(posedge clk_50_mhz) begin
    if (rst) timer_enable_n <= 1'b1;
    else     timer_enable_n <= 1'b0;
  end

  always_comb begin
    ns_lamp = LAMP_RED;
    ew_lamp = LAMP_RED;
    walk    = 1'b0;
    case (state)
      ST_NS_GREEN:  ns_lamp = LAMP_GRN;
      ST_NS_YELLOW: ns_lamp = LAMP_YEL;
      ST_EW_GREEN: begin
        ew_lamp = LAMP_GRN;
        walk    = walk_en && (count < WALK_LIM);
      end
      ST_EW_YELLOW: ew_lamp = LAMP_YEL;
      ST_FLASH: begin
        ns_lamp = flash_on ? LAMP_YEL : LAMP_OFF;
        ew_lamp = flash_on ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_intersection_controller.sv
// Scoreboard bench: a cycle reference model queues expected lamp outputs at
// each clock edge; the DUT outputs are popped and compared on the falling edge.
module tb_intersection_controller;

  localparam int unsigned NS_MIN_T = 4;
  localparam int unsigned EW_T     = 3;
  localparam int unsigned YEL_T    = 2;
  localparam int unsigned ALLRED_T = 1;
  localparam int unsigned WALK_T   = 2;
  localparam int unsigned CNT_W    = 8;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic       clk_50_mhz = 1'b0;
  logic       rst        = 1'b1;
  logic       clk_mstr   = 1'b0;
  logic       ew_sensor  = 1'b0;
  logic       ped_btn    = 1'b0;
  logic       flash      = 1'b0;
  logic       timer_enable_n;
  logic [2:0] ns_lamp, ew_lamp;
  logic       walk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned walk_cyc = 0;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic       ten_n;
  } exp_t;

  exp_t exp_q[$];

  intersection_controller #(
    .NS_MIN_T (NS_MIN_T),
    .EW_T     (EW_T),
    .YEL_T    (YEL_T),
    .ALLRED_T (ALLRED_T),
    .WALK_T   (WALK_T),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_50_mhz     (clk_50_mhz),
    .rst            (rst),
    .clk_mstr       (clk_mstr),
    .timer_enable_n (timer_enable_n),
    .ew_sensor      (ew_sensor),
    .ped_btn        (ped_btn),
    .flash          (flash),
    .ns_lamp        (ns_lamp),
    .ew_lamp        (ew_lamp),
    .walk           (walk)
  );

  always #10 clk_50_mhz = ~clk_50_mhz;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Master timer: 10-cycle square wave, changed away from the active edge
  initial begin
    int unsigned ph;
    ph = 0;
    forever begin
      @(negedge clk_50_mhz);
      ph = (ph + 1) % 10;
      clk_mstr = (ph < 5);
    end
  end

  function automatic int unsigned phase_len(input int unsigned p);
    case (p)
      0, 3, 6: return ALLRED_T;
      2, 5:    return YEL_T;
      4:       return EW_T;
      default: return 0;
    endcase
  endfunction

  // Reference model. Phases: 0 init, 1 NS grn, 2 NS yel, 3 red A,
  // 4 EW grn, 5 EW yel, 6 red B, 7 flash.
  initial begin
    int unsigned m_phase, m_secs, nxt;
    logic m_prev, m_ewr, m_pedr, m_walk_en, m_on, m_ten_n, m_tick, clr;
    exp_t e;
    m_phase = 0; m_secs = 0; m_prev = 0; m_ewr = 0; m_pedr = 0;
    m_walk_en = 0; m_on = 0; m_ten_n = 1;
    forever begin
      @(posedge clk_50_mhz);
      if (rst) begin
        m_phase = 0; m_secs = 0; m_prev = 0; m_ewr = 0; m_pedr = 0;
        m_walk_en = 0; m_on = 0; m_ten_n = 1;
      end else begin
        m_tick = clk_mstr && !m_prev;
        m_prev = clk_mstr;
        nxt = m_phase;
        if (m_phase == 7)      nxt = flash ? 7 : 0;
        else if (flash)        nxt = 7;
        else if (m_tick) begin
          if (m_phase == 1) begin
            if (m_ewr && (m_secs + 1 >= NS_MIN_T)) nxt = 2;
          end else if (m_secs + 1 == phase_len(m_phase)) begin
            nxt = (m_phase == 6) ? 1 : m_phase + 1;
          end
        end
        clr = (nxt == 4) && (m_phase != 4);
        if (clr) m_walk_en = m_pedr;
        m_ewr  = (clr ? 1'b0 : m_ewr)  | ew_sensor | ped_btn;
        m_pedr = (clr ? 1'b0 : m_pedr) | ped_btn;
        if (nxt == 7 && m_phase != 7)   m_on = 1'b1;
        else if (m_phase == 7 && m_tick) m_on = ~m_on;
        if (nxt != m_phase)              m_secs = 0;
        else if (m_tick && m_secs < 255) m_secs++;
        m_phase = nxt;
        m_ten_n = 1'b0;
      end
      e.ns = RED; e.ew = RED; e.walk = 1'b0; e.ten_n = m_ten_n;
      case (m_phase)
        1: e.ns = GRN;
        2: e.ns = YEL;
        4: begin e.ew = GRN; e.walk = m_walk_en && (m_secs < WALK_T); end
        5: e.ew = YEL;
        7: begin e.ns = m_on ? YEL : OFF; e.ew = m_on ? RED : OFF; end
        default: ;
      endcase
      exp_q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_50_mhz);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("ns_lamp", 32'(ns_lamp), 32'(e.ns));
        check_eq("ew_lamp", 32'(ew_lamp), 32'(e.ew));
        check_eq("walk", 32'(walk), 32'(e.walk));
        check_eq("timer_enable_n", 32'(timer_enable_n), 32'(e.ten_n));
        check_eq("cross_safety",
                 32'((ns_lamp == RED) || (ew_lamp == RED) ||
                     (dut.state == traffic_pkg::ST_FLASH)), 32'd1);
        if (walk) walk_cyc++;
      end
    end
  end

  task automatic wait_lamp(input bit on_ew, input logic [2:0] lamp, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_50_mhz);
      seen = on_ew ? (ew_lamp == lamp) : (ns_lamp == lamp);
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  task automatic pulse(input bit is_ped);
    if (is_ped) ped_btn = 1'b1; else ew_sensor = 1'b1;
    @(negedge clk_50_mhz);
    ped_btn = 1'b0;
    ew_sensor = 1'b0;
  endtask

  initial begin
    int unsigned w0;
    repeat (5) @(negedge clk_50_mhz);
    rst = 1'b0;
    repeat (300) @(negedge clk_50_mhz);

    w0 = walk_cyc;
    pulse(1'b0);
    repeat (150) @(negedge clk_50_mhz);
    check_eq("walk_cycles_no_ped", walk_cyc - w0, 0);

    w0 = walk_cyc;
    pulse(1'b1);
    repeat (200) @(negedge clk_50_mhz);
    check_eq("walk_cycles_ped", walk_cyc - w0, WALK_T * 10);
    check_eq("ped_req_cleared", 32'(dut.ped_req), 0);

    pulse(1'b0);
    wait_lamp(1'b1, GRN, "reach_ew_green");
    repeat (12) @(negedge clk_50_mhz);
    flash = 1'b1;
    repeat (60) @(negedge clk_50_mhz);
    flash = 1'b0;
    repeat (150) @(negedge clk_50_mhz);

    pulse(1'b0);
    wait_lamp(1'b0, YEL, "reach_ns_yellow");
    repeat (5) @(negedge clk_50_mhz);
    rst = 1'b1;
    @(negedge clk_50_mhz);
    rst = 1'b0;
    repeat (100) @(negedge clk_50_mhz);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
